// File: rtl/cloud_renderer_if.sv
// Pixel, cloud-position, bitmap-ROM and result signals of cloud_renderer.
// master: the side that drives pixels/positions and hosts the bitmap ROM.
// slave : cloud_renderer itself.
interface cloud_renderer_if #(
  parameter int ROM_AW = 12
);
  logic              frame_clk;
  logic [9:0]        cloudX1;
  logic [9:0]        cloudY1;
  logic [9:0]        cloudX2;
  logic [9:0]        cloudY2;
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              pixel_valid;
  logic [ROM_AW-1:0] rom_addr;
  logic              rom_data;
  logic              cloud_on;
  logic              cloud_sel;
  logic              out_valid;

  modport master (
    output frame_clk, cloudX1, cloudY1, cloudX2, cloudY2,
    output DrawX, DrawY, pixel_valid, rom_data,
    input  rom_addr, cloud_on, cloud_sel, out_valid
  );

  modport slave (
    input  frame_clk, cloudX1, cloudY1, cloudX2, cloudY2,
    input  DrawX, DrawY, pixel_valid, rom_data,
    output rom_addr, cloud_on, cloud_sel, out_valid
  );
endinterface

// File: rtl/cloud_renderer.sv
// cloud_renderer: latches two cloud positions once per frame and, for every
// pixel, runs a 3-cycle pipelined hit test against the cloud boxes, reads
// the 1-bit cloud bitmap from an external synchronous ROM and reports
// whether the pixel is opaque cloud and which cloud owns it (cloud 1 wins).
// Optional macro CLOUD_WRAP_EN: the part of a cloud beyond the right screen
// edge reappears at the left edge; without it such parts are clipped.
module cloud_renderer #(
  parameter int CLOUD_W  = 80,
  parameter int CLOUD_H  = 40,
  parameter int SCREEN_W = 640,
  parameter int ROM_AW   = 12
) (
  input logic              Clk,
  input logic              Reset,
  cloud_renderer_if.slave  bus
);

  localparam logic [9:0] CLOUD_W_C = 10'(CLOUD_W);
  localparam logic [9:0] CLOUD_H_C = 10'(CLOUD_H);
`ifdef CLOUD_WRAP_EN
  localparam logic [9:0] SCREEN_W_C = 10'(SCREEN_W);
`endif

  // Elaboration-time sanity check of the geometry parameters.
  if ((SCREEN_W > 1024) || (CLOUD_W * CLOUD_H > (1 << ROM_AW))) begin : g_bad_params
    $error("cloud_renderer: SCREEN_W or CLOUD_W*CLOUD_H out of range");
  end

  // frame latch state
  logic              fc_d_r;
  logic [9:0]        sx1_r, sy1_r, sx2_r, sy2_r;
  logic              frame_edge_s;

  // stage 1 combinational
  logic [9:0]        dx1_s, dy1_s, dx2_s, dy2_s;
  logic [9:0]        col1_s, col2_s;
  logic              inx1_s, inx2_s;
  logic              hit1_s, hit2_s, hit_s, sel_s;
  logic [9:0]        dx_sel_s, dy_sel_s;
  logic [ROM_AW-1:0] addr_s;
`ifdef CLOUD_WRAP_EN
  logic [9:0]        dxw1_s, dxw2_s;
`endif

  // pipeline registers
  logic              v1_r, hit_r, sel_r;
  logic              v2_r, hit2_r, sel2_r;
  logic [ROM_AW-1:0] rom_addr_r;
  logic              cloud_on_r, cloud_sel_r, out_valid_r;

  assign frame_edge_s = bus.frame_clk & ~fc_d_r;

  // Unsigned wrap-around offsets: pixels left of / above a cloud become large.
  assign dx1_s = bus.DrawX - sx1_r;
  assign dy1_s = bus.DrawY - sy1_r;
  assign dx2_s = bus.DrawX - sx2_r;
  assign dy2_s = bus.DrawY - sy2_r;
`ifdef CLOUD_WRAP_EN
  assign dxw1_s = bus.DrawX + SCREEN_W_C - sx1_r;
  assign dxw2_s = bus.DrawX + SCREEN_W_C - sx2_r;
`endif

  // Edge-detect frame_clk and capture the cloud positions once per frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fc_d_r <= 1'b0;
      sx1_r  <= 10'd0;
      sy1_r  <= 10'd0;
      sx2_r  <= 10'd0;
      sy2_r  <= 10'd0;
    end else begin
      fc_d_r <= bus.frame_clk;
      if (frame_edge_s) begin
        sx1_r <= bus.cloudX1;
        sy1_r <= bus.cloudY1;
        sx2_r <= bus.cloudX2;
        sy2_r <= bus.cloudY2;
      end else begin
        sx1_r <= sx1_r;
        sy1_r <= sy1_r;
        sx2_r <= sx2_r;
        sy2_r <= sy2_r;
      end
    end
  end

  // Box hit test per cloud, cloud-1 priority and bitmap address selection.
  always_comb begin
    col1_s   = dx1_s;
    col2_s   = dx2_s;
    inx1_s   = (dx1_s < CLOUD_W_C);
    inx2_s   = (dx2_s < CLOUD_W_C);
    dx_sel_s = 10'd0;
    dy_sel_s = 10'd0;
`ifdef CLOUD_WRAP_EN
    if (!inx1_s && (dxw1_s < CLOUD_W_C)) begin
      inx1_s = 1'b1;
      col1_s = dxw1_s;
    end else begin
      col1_s = col1_s;
    end
    if (!inx2_s && (dxw2_s < CLOUD_W_C)) begin
      inx2_s = 1'b1;
      col2_s = dxw2_s;
    end else begin
      col2_s = col2_s;
    end
`endif
    hit1_s = inx1_s & (dy1_s < CLOUD_H_C);
    hit2_s = inx2_s & (dy2_s < CLOUD_H_C);
    sel_s  = ~hit1_s & hit2_s;
    hit_s  = hit1_s | hit2_s;
    if (hit1_s) begin
      dx_sel_s = col1_s;
      dy_sel_s = dy1_s;
    end else if (hit2_s) begin
      dx_sel_s = col2_s;
      dy_sel_s = dy2_s;
    end else begin
      dx_sel_s = 10'd0;
      dy_sel_s = 10'd0;
    end
    addr_s = ROM_AW'(dy_sel_s) * ROM_AW'(CLOUD_W) + ROM_AW'(dx_sel_s);
  end

  // Stage 1: register hit result and issue the ROM address.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      v1_r       <= 1'b0;
      hit_r      <= 1'b0;
      sel_r      <= 1'b0;
      rom_addr_r <= {ROM_AW{1'b0}};
    end else begin
      v1_r       <= bus.pixel_valid;
      hit_r      <= hit_s;
      sel_r      <= sel_s;
      rom_addr_r <= addr_s;
    end
  end

  // Stage 2: carry hit/sel alongside the ROM read.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      v2_r   <= 1'b0;
      hit2_r <= 1'b0;
      sel2_r <= 1'b0;
    end else begin
      v2_r   <= v1_r;
      hit2_r <= hit_r;
      sel2_r <= sel_r;
    end
  end

  // Output stage: combine hit with the bitmap bit into registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cloud_on_r  <= 1'b0;
      cloud_sel_r <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      cloud_on_r  <= v2_r & hit2_r & bus.rom_data;
      cloud_sel_r <= sel2_r;
      out_valid_r <= v2_r;
    end
  end

  assign bus.rom_addr  = rom_addr_r;
  assign bus.cloud_on  = cloud_on_r;
  assign bus.cloud_sel = cloud_sel_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_cloud_renderer.sv
// Directed testbench for cloud_renderer with a behavioural sync bitmap ROM.
module tb_cloud_renderer;
  logic Clk;
  logic Reset;
  int   checks;
  int   failures;
  logic rom_mem [0:4095];

  cloud_renderer_if #(.ROM_AW(12)) bus ();

  cloud_renderer #(
    .CLOUD_W(80), .CLOUD_H(40), .SCREEN_W(640), .ROM_AW(12)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One-cycle synchronous bitmap ROM model.
  always @(posedge Clk) bus.rom_data <= rom_mem[bus.rom_addr];

  task automatic frame_load(input logic [9:0] x1, y1, x2, y2);
    @(negedge Clk);
    bus.cloudX1 = x1; bus.cloudY1 = y1;
    bus.cloudX2 = x2; bus.cloudY2 = y2;
    bus.frame_clk = 1'b1;
    @(negedge Clk);
    bus.frame_clk = 1'b0;
  endtask

  // Send one pixel (optionally alongside a frame edge) and check address and result.
  task automatic pixel_check(input string name, input logic [9:0] x, y, input logic pulse,
                             input logic [11:0] exp_addr, input logic exp_on, input logic exp_sel);
    @(negedge Clk);
    bus.DrawX = x; bus.DrawY = y; bus.pixel_valid = 1'b1;
    bus.frame_clk = pulse;
    @(posedge Clk); #1;
    checks++;
    if (bus.rom_addr !== exp_addr) begin
      failures++;
      $display("FAIL %s_rom_addr: got %0d expected %0d", name, bus.rom_addr, exp_addr);
    end
    @(negedge Clk);
    bus.pixel_valid = 1'b0;
    bus.frame_clk = 1'b0;
    @(posedge Clk);
    @(posedge Clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_out_valid: got %b expected 1", name, bus.out_valid);
    end
    checks++;
    if (bus.cloud_on !== exp_on) begin
      failures++;
      $display("FAIL %s_cloud_on: got %b expected %b", name, bus.cloud_on, exp_on);
    end
    if (exp_on) begin
      checks++;
      if (bus.cloud_sel !== exp_sel) begin
        failures++;
        $display("FAIL %s_cloud_sel: got %b expected %b", name, bus.cloud_sel, exp_sel);
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus.frame_clk = 1'b0; bus.pixel_valid = 1'b0;
    bus.DrawX = 10'd0; bus.DrawY = 10'd0;
    bus.cloudX1 = 10'd0; bus.cloudY1 = 10'd0; bus.cloudX2 = 10'd0; bus.cloudY2 = 10'd0;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if ({bus.rom_addr, bus.cloud_on, bus.cloud_sel, bus.out_valid} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs: got addr=%0d on=%b sel=%b valid=%b expected all 0",
               bus.rom_addr, bus.cloud_on, bus.cloud_sel, bus.out_valid);
    end
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_basic();
    frame_load(10'd100, 10'd20, 10'd500, 10'd300);
    pixel_check("basic_hit", 10'd100, 10'd20, 1'b0, 12'd0, 1'b1, 1'b0);
  endtask

  task automatic test_boundary();
    pixel_check("last_col_row", 10'd179, 10'd59, 1'b0, 12'd3199, 1'b1, 1'b0);
    pixel_check("col_miss",     10'd180, 10'd59, 1'b0, 12'd0,    1'b0, 1'b0);
    pixel_check("row_miss",     10'd179, 10'd60, 1'b0, 12'd0,    1'b0, 1'b0);
    pixel_check("left_miss",    10'd99,  10'd20, 1'b0, 12'd0,    1'b0, 1'b0);
    pixel_check("above_miss",   10'd100, 10'd19, 1'b0, 12'd0,    1'b0, 1'b0);
  endtask

  task automatic test_priority();
    frame_load(10'd200, 10'd20, 10'd200, 10'd20);
    pixel_check("same_pos",    10'd210, 10'd25, 1'b0, 12'd410, 1'b1, 1'b0);
    pixel_check("transparent", 10'd211, 10'd25, 1'b0, 12'd411, 1'b0, 1'b0);
    frame_load(10'd200, 10'd20, 10'd400, 10'd100);
    pixel_check("cloud2_only", 10'd405, 10'd101, 1'b0, 12'd85, 1'b1, 1'b1);
    frame_load(10'd200, 10'd20, 10'd240, 10'd30);
    pixel_check("overlap_c1",  10'd250, 10'd35, 1'b0, 12'd1250, 1'b1, 1'b0);
    pixel_check("overlap_c2",  10'd290, 10'd35, 1'b0, 12'd450,  1'b1, 1'b1);
  endtask

  task automatic test_frame_latch();
    frame_load(10'd100, 10'd20, 10'd500, 10'd300);
    @(negedge Clk);
    bus.cloudX1 = 10'd300;
    pixel_check("ignore_change",   10'd100, 10'd20, 1'b0, 12'd0, 1'b1, 1'b0);
    pixel_check("edge_same_cycle", 10'd100, 10'd20, 1'b1, 12'd0, 1'b1, 1'b0);
    pixel_check("after_edge_old",  10'd100, 10'd20, 1'b0, 12'd0, 1'b0, 1'b0);
    pixel_check("after_edge_new",  10'd300, 10'd20, 1'b0, 12'd0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_flush();
    logic vp [5]    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic rp [5]    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic exp_v [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      bus.DrawX = 10'd5; bus.DrawY = 10'd5;
      if (i < 5) begin
        bus.pixel_valid = vp[i];
        Reset = rp[i];
      end else begin
        bus.pixel_valid = 1'b0;
        Reset = 1'b0;
      end
      @(posedge Clk); #1;
      checks++;
      if (bus.out_valid !== exp_v[i]) begin
        failures++;
        $display("FAIL flush_out_valid[%0d]: got %b expected %b", i, bus.out_valid, exp_v[i]);
      end
      checks++;
      if (bus.cloud_on !== exp_v[i]) begin
        failures++;
        $display("FAIL flush_cloud_on[%0d]: got %b expected %b", i, bus.cloud_on, exp_v[i]);
      end
      if (i == 3) begin
        checks++;
        if (bus.rom_addr !== 12'd405) begin
          failures++;
          $display("FAIL flush_rom_addr: got %0d expected 405", bus.rom_addr);
        end
      end
    end
  endtask

  task automatic test_wrap();
    frame_load(10'd620, 10'd20, 10'd0, 10'd300);
`ifdef CLOUD_WRAP_EN
    pixel_check("wrap_hit", 10'd10, 10'd30, 1'b0, 12'd830, 1'b1, 1'b0);
`else
    pixel_check("wrap_clip", 10'd10, 10'd30, 1'b0, 12'd0, 1'b0, 1'b0);
`endif
    frame_load(10'd700, 10'd20, 10'd0, 10'd300);
    pixel_check("x700_right_edge", 10'd639, 10'd20, 1'b0, 12'd0, 1'b0, 1'b0);
`ifdef CLOUD_WRAP_EN
    pixel_check("x700_wrap", 10'd60, 10'd20, 1'b0, 12'd0, 1'b1, 1'b0);
`else
    pixel_check("x700_clip", 10'd60, 10'd20, 1'b0, 12'd0, 1'b0, 1'b0);
`endif
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int a = 0; a < 4096; a++) rom_mem[a] = 1'b1;
    rom_mem[411] = 1'b0;
    test_reset();
    test_basic();
    test_boundary();
    test_priority();
    test_frame_latch();
    test_reset_flush();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
